// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
//
// Purpose : Shared encodings and helpers for the AHB-Lite bus arbiter.
//           Holds the HTRANS and HBURST encodings and the arbiter state
//           enum. It also provides the burst-length lookup that gives the
//           number of beats still to come after a NONSEQ.
//
// Configuration macro: AHB_ARBITER_LOCK_EN
//           When defined, the state enum gains the LOCKED encoding used by
//           the locked-transfer support in ahb_arbiter.
//
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    // HBURST burst types
    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // Width of the remaining-beat counter; 15 is the longest tail (INCR16).
    localparam int BEAT_CNT_W = 4;

    // Arbiter state. BURST takes priority over LOCKED when both apply,
    // so BURST always means "beat counter is non-zero".
`ifdef AHB_ARBITER_LOCK_EN
    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_BURST  = 2'd2,
        ARB_LOCKED = 2'd3
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_BURST  = 2'd2
    } arb_state_e;
`endif

    // Number of SEQ beats that follow the NONSEQ of a fixed-length burst.
    // SINGLE and undefined-length INCR have no counted tail.
    function automatic logic [BEAT_CNT_W-1:0] burst_beats_left(input logic [2:0] hburst);
        logic [BEAT_CNT_W-1:0] beats;
        beats = '0;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arb_rr_picker.sv
// ---------------------------------------------------------------------------
// ahb_arb_rr_picker
//
// Purpose : Combinational round-robin selector. It searches the request
//           vector starting one above the last owner, wraps modulo
//           NO_OF_MANAGERS, and returns the first requester found. The last
//           owner is the final candidate, so a lone requesting owner keeps
//           the bus.
//
// Ports   :
//   req        in   NO_OF_MANAGERS     request vector
//   last_owner in   BITS_FOR_MANAGERS  current owner index (always < N)
//   winner     out  BITS_FOR_MANAGERS  selected index (0 when !valid)
//   valid      out  1                  at least one request is set
// ---------------------------------------------------------------------------
module ahb_arb_rr_picker #(
    parameter int NO_OF_MANAGERS    = 4,
    parameter int BITS_FOR_MANAGERS = $clog2(NO_OF_MANAGERS)
) (
    input  logic [NO_OF_MANAGERS-1:0]    req,
    input  logic [BITS_FOR_MANAGERS-1:0] last_owner,
    output logic [BITS_FOR_MANAGERS-1:0] winner,
    output logic                         valid
);

    // One extra bit so owner + offset (at most 2N-1) cannot overflow before
    // the modulo-N fold.
    localparam int CW = BITS_FOR_MANAGERS + 1;

    // Walk the offsets from farthest to nearest. The nearest requester is
    // assigned last, so it wins. Folding by subtracting N (not by bit
    // truncation) keeps the candidate inside the populated index range
    // when N is not a power of two.
    always_comb begin
        logic [CW-1:0] cand;
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = NO_OF_MANAGERS; i >= 1; i--) begin
            cand = {1'b0, last_owner} + CW'(i);
            if (cand >= CW'(NO_OF_MANAGERS)) begin
                cand = cand - CW'(NO_OF_MANAGERS);
            end
            if (req[cand[BITS_FOR_MANAGERS-1:0]]) begin
                winner = cand[BITS_FOR_MANAGERS-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Purpose : AHB-Lite multi-manager arbiter. It grants one manager at a time
//           and keeps fixed-length bursts intact with a remaining-beat
//           counter. It parks on DEFAULT_MANAGER when nobody requests. It
//           produces the address-phase owner (HMASTER) and the data-phase
//           owner (HMASTER_D) for the bus muxes.
//
// Configuration macro: AHB_ARBITER_LOCK_EN
//           Defined  : honours HLOCKx. The grant is held while the owner is
//                      locked, plus one arbitration point after the lock
//                      drops. HMASTLOCK is registered with HMASTER.
//           Undefined: HLOCKx is ignored and HMASTLOCK is tied low.
//
// Ports   :
//   HCLK       in   1                  bus clock, rising edge
//   HRESET     in   1                  asynchronous active-high reset
//   HBUSREQ    in   NO_OF_MANAGERS     per-manager bus request
//   HLOCKx     in   NO_OF_MANAGERS     per-manager lock request
//   HTRANS     in   2                  transfer type of address-phase owner
//   HBURST     in   3                  burst type of address-phase owner
//   HREADY     in   1                  bus ready
//   HGRANT     out  NO_OF_MANAGERS     registered one-hot grant
//   HMASTER    out  BITS_FOR_MANAGERS  address-phase owner index
//   HMASTER_D  out  BITS_FOR_MANAGERS  data-phase owner index
//   HMASTLOCK  out  1                  current address phase is locked
// ---------------------------------------------------------------------------
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NO_OF_MANAGERS    = 4,
    parameter int BITS_FOR_MANAGERS = $clog2(NO_OF_MANAGERS),
    parameter int DEFAULT_MANAGER   = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [NO_OF_MANAGERS-1:0]    HBUSREQ,
    input  logic [NO_OF_MANAGERS-1:0]    HLOCKx,
    input  logic [1:0]                   HTRANS,
    input  logic [2:0]                   HBURST,
    input  logic                         HREADY,
    output logic [NO_OF_MANAGERS-1:0]    HGRANT,
    output logic [BITS_FOR_MANAGERS-1:0] HMASTER,
    output logic [BITS_FOR_MANAGERS-1:0] HMASTER_D,
    output logic                         HMASTLOCK
);

    localparam logic [BITS_FOR_MANAGERS-1:0] DEFAULT_IDX = BITS_FOR_MANAGERS'(DEFAULT_MANAGER);
    localparam logic [NO_OF_MANAGERS-1:0]    DEFAULT_OH  = NO_OF_MANAGERS'(1) << DEFAULT_MANAGER;

    // Registered state
    logic [BITS_FOR_MANAGERS-1:0] grant_idx_q,  grant_idx_d;
    logic [NO_OF_MANAGERS-1:0]    grant_q,      grant_d;
    logic [BITS_FOR_MANAGERS-1:0] addr_owner_q, addr_owner_d;
    logic [BITS_FOR_MANAGERS-1:0] data_owner_q, data_owner_d;
    logic [BEAT_CNT_W-1:0]        beat_cnt_q,   beat_cnt_d;
    arb_state_e                   state_q,      state_d;

    // Combinational helpers
    logic [BEAT_CNT_W-1:0]        burst_load;
    logic                         owner_req;
    logic                         arb_point;
    logic                         lock_hold;
    logic [BITS_FOR_MANAGERS-1:0] pick_idx;
    logic                         pick_valid;

`ifdef AHB_ARBITER_LOCK_EN
    logic mastlock_q, mastlock_d;
`else
    logic unused_lock_bits;
    assign unused_lock_bits = ^HLOCKx;
`endif

    ahb_arb_rr_picker #(
        .NO_OF_MANAGERS    (NO_OF_MANAGERS),
        .BITS_FOR_MANAGERS (BITS_FOR_MANAGERS)
    ) u_picker (
        .req        (HBUSREQ),
        .last_owner (grant_idx_q),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

    // Beat counting and the arbitration-point decision.
    // "Owner" is the currently granted manager. Its request line decides
    // when an undefined-length INCR burst may be handed over.
    always_comb begin
        burst_load = burst_beats_left(HBURST);
        owner_req  = HBUSREQ[grant_idx_q];

        beat_cnt_d = beat_cnt_q;
        if (HREADY) begin
            if (HTRANS == HTRANS_NONSEQ) begin
                beat_cnt_d = burst_load;
            end else if (HTRANS == HTRANS_SEQ && state_q == ARB_BURST) begin
                // Only counted bursts decrement; INCR SEQs leave 0 alone.
                beat_cnt_d = beat_cnt_q - 4'd1;
            end
        end

        arb_point = HREADY && (
                        (HTRANS == HTRANS_IDLE) ||
                        (HTRANS == HTRANS_NONSEQ && burst_load == '0 && HBURST != HBURST_INCR) ||
                        (HTRANS == HTRANS_SEQ && beat_cnt_q == 4'd1) ||
                        (HBURST == HBURST_INCR && !owner_req &&
                         HTRANS != HTRANS_SEQ && HTRANS != HTRANS_BUSY));
    end

    // Lock handling: the owner's live lock holds the grant. The registered
    // lock of the phase in flight also holds it, which adds the one extra
    // hold so the last locked data phase finishes before handover.
`ifdef AHB_ARBITER_LOCK_EN
    always_comb begin
        lock_hold  = HLOCKx[grant_idx_q] | mastlock_q;
        mastlock_d = HREADY ? HLOCKx[grant_idx_q] : mastlock_q;
    end
`else
    assign lock_hold = 1'b0;
`endif

    // Grant selection and owner pipeline. HMASTER follows the grant on the
    // next ready edge, and HMASTER_D follows HMASTER one accepted transfer
    // later. With no request at an arbitration point, the grant parks on
    // DEFAULT_MANAGER.
    always_comb begin
        grant_idx_d = grant_idx_q;
        if (arb_point && !lock_hold) begin
            grant_idx_d = pick_valid ? pick_idx : DEFAULT_IDX;
        end

        grant_d              = '0;
        grant_d[grant_idx_d] = 1'b1;

        addr_owner_d = HREADY ? grant_idx_q  : addr_owner_q;
        data_owner_d = HREADY ? addr_owner_q : data_owner_q;
    end

    // State classification. Later assignments take priority: BURST beats
    // LOCKED, and LOCKED beats PARK/OWNED.
    always_comb begin
        state_d = ARB_OWNED;
        if (!(|HBUSREQ) && grant_idx_d == DEFAULT_IDX) begin
            state_d = ARB_PARK;
        end
`ifdef AHB_ARBITER_LOCK_EN
        if (mastlock_d) begin
            state_d = ARB_LOCKED;
        end
`endif
        if (beat_cnt_d != '0) begin
            state_d = ARB_BURST;
        end
    end

    // All arbiter state, cleared asynchronously to the parked condition.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_idx_q  <= DEFAULT_IDX;
            grant_q      <= DEFAULT_OH;
            addr_owner_q <= DEFAULT_IDX;
            data_owner_q <= DEFAULT_IDX;
            beat_cnt_q   <= '0;
            state_q      <= ARB_PARK;
`ifdef AHB_ARBITER_LOCK_EN
            mastlock_q   <= 1'b0;
`endif
        end else begin
            grant_idx_q  <= grant_idx_d;
            grant_q      <= grant_d;
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            state_q      <= state_d;
`ifdef AHB_ARBITER_LOCK_EN
            mastlock_q   <= mastlock_d;
`endif
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = addr_owner_q;
    assign HMASTER_D = data_owner_q;
`ifdef AHB_ARBITER_LOCK_EN
    assign HMASTLOCK = mastlock_q;
`else
    assign HMASTLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Bench for ahb_arbiter (4 managers, default manager 0). Each stimulus step
// queues the outputs it expects after the next rising edge. A monitor pops
// and compares those outputs shortly after that edge. Expected values are
// written out by hand from the arbitration rules. Lock-dependent steps pick
// their expectation based on AHB_ARBITER_LOCK_EN.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;
    import ahb_arb_pkg::*;

`ifdef AHB_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCKx;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    int checks   = 0;
    int failures = 0;
    int step_id  = 0;

    typedef struct packed {
        int         step;
        logic [3:0] grant;
        logic [1:0] master;
        logic [1:0] master_d;
        logic       lock;
    } exp_t;

    exp_t exp_q[$];

    ahb_arbiter #(
        .NO_OF_MANAGERS    (4),
        .BITS_FOR_MANAGERS (2),
        .DEFAULT_MANAGER   (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCKx    (HLOCKx),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Count one comparison and report it when it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected after the following rising edge
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic ready, input logic [3:0] e_grant,
                                 input logic [1:0] e_master, input logic [1:0] e_master_d,
                                 input logic e_lock);
        exp_t e;
        @(negedge HCLK);
        HBUSREQ = req;
        HLOCKx  = lock;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = ready;
        step_id++;
        e.step     = step_id;
        e.grant    = e_grant;
        e.master   = e_master;
        e.master_d = e_master_d;
        e.lock     = e_lock;
        exp_q.push_back(e);
    endtask

    // Scoreboard side: compare queued expectations just after each edge
    always @(posedge HCLK) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("s%0d.grant", e.step),    32'(HGRANT),    32'(e.grant));
            checkOutput($sformatf("s%0d.master", e.step),   32'(HMASTER),   32'(e.master));
            checkOutput($sformatf("s%0d.master_d", e.step), 32'(HMASTER_D), 32'(e.master_d));
            checkOutput($sformatf("s%0d.mastlock", e.step), 32'(HMASTLOCK), 32'(e.lock));
        end
    end

    // Watchdog so the run always ends with a summary
    initial begin
        #200000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    localparam logic [1:0] I = HTRANS_IDLE;
    localparam logic [1:0] B = HTRANS_BUSY;
    localparam logic [1:0] N = HTRANS_NONSEQ;
    localparam logic [1:0] S = HTRANS_SEQ;

    initial begin
        HRESET  = 1'b1;
        HBUSREQ = '0;
        HLOCKx  = '0;
        HTRANS  = HTRANS_IDLE;
        HBURST  = HBURST_SINGLE;
        HREADY  = 1'b1;

        // Reset values
        #12;
        checkOutput("reset.grant",    32'(HGRANT),    32'h1);
        checkOutput("reset.master",   32'(HMASTER),   32'h0);
        checkOutput("reset.master_d", 32'(HMASTER_D), 32'h0);
        checkOutput("reset.mastlock", 32'(HMASTLOCK), 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;

        $display("[TB] parked single request");
        applyStimulus(4'b0100, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);  // s1
        applyStimulus(4'b0100, 4'b0000, I, HBURST_SINGLE, 1'b0, 4'b0100, 2'd0, 2'd0, 1'b0);  // s2 wait
        applyStimulus(4'b0100, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0);  // s3
        applyStimulus(4'b0100, 4'b0000, N, HBURST_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);  // s4

        $display("[TB] INCR4 with contention");
        applyStimulus(4'b0010, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0);
        applyStimulus(4'b0010, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);
        applyStimulus(4'b1010, 4'b0000, N, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
        applyStimulus(4'b1010, 4'b0000, S, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
        applyStimulus(4'b1010, 4'b0000, S, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
        applyStimulus(4'b1010, 4'b0000, S, HBURST_INCR4,  1'b1, 4'b1000, 2'd1, 2'd1, 1'b0);
        applyStimulus(4'b1000, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0);

        $display("[TB] round-robin fairness");
        applyStimulus(4'b1111, 4'b0000, N, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0);
        applyStimulus(4'b1111, 4'b0000, N, HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 2'd3, 1'b0);
        applyStimulus(4'b1111, 4'b0000, N, HBURST_SINGLE, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
        applyStimulus(4'b1111, 4'b0000, N, HBURST_SINGLE, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0);
        applyStimulus(4'b1111, 4'b0000, N, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 2'd2, 1'b0);
        applyStimulus(4'b1111, 4'b0000, N, HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 2'd3, 1'b0);

        $display("[TB] wait states inside INCR8");
        applyStimulus(4'b0010, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
        applyStimulus(4'b0011, 4'b0000, N, HBURST_INCR8,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);  // beat 1
        applyStimulus(4'b0011, 4'b0000, S, HBURST_INCR8,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);  // beat 2
        applyStimulus(4'b0011, 4'b0000, S, HBURST_INCR8,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);  // beat 3
        for (int w = 0; w < 3; w++) begin
            applyStimulus(4'b0011, 4'b0000, S, HBURST_INCR8, 1'b0, 4'b0010, 2'd1, 2'd1, 1'b0);
        end
        for (int b = 4; b <= 7; b++) begin
            applyStimulus(4'b0011, 4'b0000, S, HBURST_INCR8, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
        end
        applyStimulus(4'b0011, 4'b0000, S, HBURST_INCR8,  1'b1, 4'b0001, 2'd1, 2'd1, 1'b0);  // beat 8
        applyStimulus(4'b0001, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd1, 1'b0);

        $display("[TB] locked bursts");
        applyStimulus(4'b0100, 4'b0100, I, HBURST_SINGLE, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);
        applyStimulus(4'b0100, 4'b0100, I, HBURST_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, N, HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, S, HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, S, HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, S, HBURST_INCR4,  1'b1,
                      LOCK_EN ? 4'b0100 : 4'b0001, 2'd2, 2'd2, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, N, HBURST_INCR4,  1'b1,
                      LOCK_EN ? 4'b0100 : 4'b0001, LOCK_EN ? 2'd2 : 2'd0, 2'd2, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, S, HBURST_INCR4,  1'b1,
                      LOCK_EN ? 4'b0100 : 4'b0001, LOCK_EN ? 2'd2 : 2'd0, LOCK_EN ? 2'd2 : 2'd0, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, S, HBURST_INCR4,  1'b1,
                      LOCK_EN ? 4'b0100 : 4'b0001, LOCK_EN ? 2'd2 : 2'd0, LOCK_EN ? 2'd2 : 2'd0, LOCK_EN);
        applyStimulus(4'b0101, 4'b0100, S, HBURST_INCR4,  1'b1,
                      4'b0100, LOCK_EN ? 2'd2 : 2'd0, LOCK_EN ? 2'd2 : 2'd0, LOCK_EN);
        // lock drops: one extra hold when locking is built
        applyStimulus(4'b0101, 4'b0000, I, HBURST_SINGLE, 1'b1,
                      LOCK_EN ? 4'b0100 : 4'b0001, 2'd2, LOCK_EN ? 2'd2 : 2'd0, 1'b0);
        applyStimulus(4'b0101, 4'b0000, I, HBURST_SINGLE, 1'b1,
                      LOCK_EN ? 4'b0001 : 4'b0100, LOCK_EN ? 2'd2 : 2'd0, 2'd2, 1'b0);
        applyStimulus(4'b0100, 4'b0000, I, HBURST_SINGLE, 1'b1,
                      4'b0100, LOCK_EN ? 2'd0 : 2'd2, LOCK_EN ? 2'd2 : 2'd0, 1'b0);
        applyStimulus(4'b0100, 4'b0000, I, HBURST_SINGLE, 1'b1,
                      4'b0100, 2'd2, LOCK_EN ? 2'd0 : 2'd2, 1'b0);
        applyStimulus(4'b0100, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);

        $display("[TB] reset during INCR16");
        applyStimulus(4'b0110, 4'b0000, N, HBURST_INCR16, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        @(posedge HCLK);
        #3;
        HTRANS = S;
        HRESET = 1'b1;
        #1;
        checkOutput("midreset.grant",    32'(HGRANT),    32'h1);
        checkOutput("midreset.master",   32'(HMASTER),   32'h0);
        checkOutput("midreset.master_d", 32'(HMASTER_D), 32'h0);
        checkOutput("midreset.mastlock", 32'(HMASTLOCK), 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        applyStimulus(4'b1000, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b1000, 2'd0, 2'd0, 1'b0);
        applyStimulus(4'b1000, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b1000, 2'd3, 2'd0, 1'b0);

        $display("[TB] park and undefined-length INCR");
        applyStimulus(4'b0000, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0);
        applyStimulus(4'b0100, 4'b0000, I, HBURST_SINGLE, 1'b1, 4'b0100, 2'd0, 2'd3, 1'b0);
        applyStimulus(4'b0110, 4'b0000, N, HBURST_INCR,   1'b1, 4'b0100, 2'd2, 2'd0, 1'b0);
        applyStimulus(4'b0110, 4'b0000, S, HBURST_INCR,   1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        applyStimulus(4'b0010, 4'b0000, B, HBURST_INCR,   1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        applyStimulus(4'b0010, 4'b0000, N, HBURST_INCR,   1'b1, 4'b0010, 2'd2, 2'd2, 1'b0);

        // Let the scoreboard drain, bounded
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
            @(posedge HCLK);
            #2;
        end
        checkOutput("drain.pending", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
